fft_input_buffer: RTL and testbench

Front-end stage of the 16-point radix-4 FFT peripheral. It accepts complex samples from the openMSP430 peripheral bus one word at a time and collects 16 of them. It then presents all 16 samples at once, in first-stage butterfly order, to the four parallel radix-4 butterflies through a valid/ready handshake. It also reports fill status back to software.

---
 rtl/fft_input_buffer_if.sv | 23 ++
 rtl/fft_input_buffer.sv | 135 +++++++++++++
 tb/tb_fft_input_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_buffer_if.sv
// Bus and frame-output signals of the FFT input buffer: peripheral bus side and
// the 16-sample valid/ready frame toward the radix-4 butterflies.
interface fft_input_buffer_if;
  logic         per_en;
  logic [1:0]   per_we;
  logic [13:0]  per_addr;
  logic [15:0]  per_din;
  logic [15:0]  per_dout;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] xr_flat;
  logic [255:0] xi_flat;

  modport master (
    output per_en, per_we, per_addr, per_din, out_ready,
    input  per_dout, out_valid, xr_flat, xi_flat
  );

  modport slave (
    input  per_en, per_we, per_addr, per_din, out_ready,
    output per_dout, out_valid, xr_flat, xi_flat
  );
endinterface

// File: rtl/fft_input_buffer.sv
// Collects 16 complex samples from the peripheral bus and presents them as one
// frame in first-stage radix-4 butterfly order via a valid/ready handshake.
module fft_input_buffer #(
  parameter logic [13:0] BASE_ADDR = 14'h0A0
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  fft_input_buffer_if.slave    bus
);

  localparam int unsigned N_SAMPLES = 16;
  localparam int unsigned DW        = 16;
  localparam int unsigned CW        = 5;
  localparam int unsigned PW        = 4;

  localparam logic [13:0] ADDR_CTRL = BASE_ADDR;
  localparam logic [13:0] ADDR_DATR = BASE_ADDR + 14'd1;
  localparam logic [13:0] ADDR_DATI = BASE_ADDR + 14'd2;

  typedef enum logic {FILL, PRESENT} state_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic          ovf, ovf_nxt;
  logic [DW-1:0] re_stage, re_stage_nxt;
  logic          commit;
  logic          out_valid_q;
  sample_t       mem [N_SAMPLES];

  logic wr_word, rd_word, clr, datar_wr, datai_wr, full;

  // Byte writes (per_we 01/10) match neither decode and are dropped.
  assign wr_word  = bus.per_en && (bus.per_we == 2'b11);
  assign rd_word  = bus.per_en && (bus.per_we == 2'b00);
  assign clr      = wr_word && (bus.per_addr == ADDR_CTRL) && bus.per_din[1];
  assign datar_wr = wr_word && (bus.per_addr == ADDR_DATR);
  assign datai_wr = wr_word && (bus.per_addr == ADDR_DATI);
  assign full     = (count == CW'(N_SAMPLES));

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state       <= FILL;
      count       <= '0;
      wr_ptr      <= '0;
      ovf         <= 1'b0;
      re_stage    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      wr_ptr      <= wr_ptr_nxt;
      ovf         <= ovf_nxt;
      re_stage    <= re_stage_nxt;
      out_valid_q <= (state_nxt == PRESENT);
    end
  end

  // Sample register file; only written while filling.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      for (int i = 0; i < int'(N_SAMPLES); i++) mem[i] <= '0;
    end else if (commit) begin
      mem[wr_ptr] <= '{re: re_stage, im: bus.per_din};
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    wr_ptr_nxt   = wr_ptr;
    ovf_nxt      = ovf;
    re_stage_nxt = re_stage;
    commit       = 1'b0;

    unique case (state)
      FILL: begin
        if (datar_wr) re_stage_nxt = bus.per_din;
        if (datai_wr) begin
          commit     = 1'b1;
          wr_ptr_nxt = wr_ptr + PW'(1);
          count_nxt  = count + CW'(1);
          if (count == CW'(N_SAMPLES - 1)) state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (datar_wr || datai_wr) ovf_nxt = 1'b1;
        if (bus.out_ready) begin
          state_nxt  = FILL;
          count_nxt  = '0;
          wr_ptr_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase

    // CLR overrides a coincident handshake.
    if (clr) begin
      state_nxt  = FILL;
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      ovf_nxt    = 1'b0;
    end
  end

  // Butterfly k, input j receives sample k+4j.
  always_comb begin
    bus.xr_flat = '0;
    bus.xi_flat = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        bus.xr_flat[16*(4*k+j) +: 16] = mem[k+4*j].re;
        bus.xi_flat[16*(4*k+j) +: 16] = mem[k+4*j].im;
      end
    end
  end

  assign bus.out_valid = out_valid_q;

  always_comb begin
    bus.per_dout = '0;
    if (rd_word) begin
      if (bus.per_addr == ADDR_CTRL)
        bus.per_dout = {7'b0, count, 1'b0, ovf, out_valid_q, full};
      else if (bus.per_addr == ADDR_DATR)
        bus.per_dout = re_stage;
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed scenarios plus random bus traffic, checked every cycle against a
// sample-count based reference model of the FFT input buffer.
module tb_fft_input_buffer;

  localparam logic [13:0] B = 14'h0A0;

  logic mclk = 1'b0;
  logic puc_rst;

  fft_input_buffer_if bus_if();

  fft_input_buffer #(.BASE_ADDR(B)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus_if)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: the frame is present exactly when 16 samples are held.
  int          m_cnt;
  bit          m_ovf;
  logic [15:0] m_re;
  logic [15:0] m_sre [16];
  logic [15:0] m_sim [16];
  logic        m_wr;
  logic        m_clr;
  logic        m_dwr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_re  = '0;
      for (int i = 0; i < 16; i++) begin
        m_sre[i] = '0;
        m_sim[i] = '0;
      end
    end else begin
      m_wr  = bus_if.per_en && (bus_if.per_we == 2'b11);
      m_clr = m_wr && (bus_if.per_addr == B) && bus_if.per_din[1];
      m_dwr = m_wr && (bus_if.per_addr == B + 14'd1 || bus_if.per_addr == B + 14'd2);
      if (m_clr) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end else if (m_cnt == 16) begin
        if (m_dwr) m_ovf = 1'b1;
        if (bus_if.out_ready) m_cnt = 0;
      end else if (m_wr && bus_if.per_addr == B + 14'd1) begin
        m_re = bus_if.per_din;
      end else if (m_wr && bus_if.per_addr == B + 14'd2) begin
        m_sre[m_cnt] = m_re;
        m_sim[m_cnt] = bus_if.per_din;
        m_cnt++;
      end
    end
  end

  function automatic logic [15:0] exp_status();
    logic v;
    v = (m_cnt == 16);
    return {7'b0, 5'(m_cnt), 1'b0, m_ovf, v, v};
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge mclk) begin
    if (chk_en) begin
      logic [255:0] exr, exi;
      logic [15:0]  edout;
      for (int n = 0; n < 16; n++) begin
        exr[16*(4*(n%4) + n/4) +: 16] = m_sre[n];
        exi[16*(4*(n%4) + n/4) +: 16] = m_sim[n];
      end
      edout = '0;
      if (bus_if.per_en && bus_if.per_we == 2'b00) begin
        if (bus_if.per_addr == B)              edout = exp_status();
        else if (bus_if.per_addr == B + 14'd1) edout = m_re;
      end
      check("out_valid", 256'(bus_if.out_valid), 256'(m_cnt == 16));
      check("xr_flat", bus_if.xr_flat, exr);
      check("xi_flat", bus_if.xi_flat, exi);
      check("per_dout", 256'(bus_if.per_dout), 256'(edout));
    end
  end

  task automatic bus_cycle(input logic en, input logic [1:0] we, input logic [13:0] addr,
                           input logic [15:0] din, input logic rdy);
    @(negedge mclk);
    #1;
    bus_if.per_en    = en;
    bus_if.per_we    = we;
    bus_if.per_addr  = addr;
    bus_if.per_din   = din;
    bus_if.out_ready = rdy;
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] din);
    bus_cycle(1'b1, 2'b11, addr, din, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    bus_cycle(1'b0, 2'b00, 14'd0, 16'd0, rdy);
  endtask

  task automatic rd(input logic [13:0] addr, output logic [15:0] d);
    bus_cycle(1'b1, 2'b00, addr, 16'd0, 1'b0);
    #1;
    d = bus_if.per_dout;
  endtask

  task automatic load(input int num, input logic [15:0] re0, input logic [15:0] im0);
    for (int n = 0; n < num; n++) begin
      wr(B + 14'd1, re0 + 16'(n));
      wr(B + 14'd2, im0 + 16'(n));
    end
    idle(1'b0);
  endtask

  logic [15:0] d;
  int          r;

  initial begin
    puc_rst          = 1'b1;
    bus_if.per_en    = 1'b0;
    bus_if.per_we    = 2'b00;
    bus_if.per_addr  = '0;
    bus_if.per_din   = '0;
    bus_if.out_ready = 1'b0;
    @(posedge mclk);
    chk_en = 1'b1;
    @(negedge mclk);
    #1 puc_rst = 1'b0;
    rd(B, d);
    check("reset_status", 256'(d), 256'h0000);

    // Full frame: re = n, im = 0x100+n.
    load(16, 16'h0000, 16'h0100);
    check("frame_valid", 256'(bus_if.out_valid), 256'd1);
    check("xr_slice1", 256'(bus_if.xr_flat[16 +: 16]), 256'h0004);
    check("xr_slice4", 256'(bus_if.xr_flat[64 +: 16]), 256'h0001);
    check("xi_slice1", 256'(bus_if.xi_flat[16 +: 16]), 256'h0104);
    rd(B, d);
    check("full_status", 256'(d), 256'h0103);

    // Overflow while presenting, then handshake.
    repeat (5) idle(1'b0);
    wr(B + 14'd2, 16'hDEAD);
    idle(1'b0);
    check("ovf_frame_kept", 256'(bus_if.xi_flat[16 +: 16]), 256'h0104);
    idle(1'b1);
    idle(1'b0);
    check("valid_dropped", 256'(bus_if.out_valid), 256'd0);
    rd(B, d);
    check("ovf_status", 256'(d), 256'h0004);

    // CLR after 7 samples, then a fresh frame from index 0.
    load(7, 16'h0020, 16'h0030);
    rd(B, d);
    check("partial_status", 256'(d), 256'h0074);
    wr(B, 16'h0002);
    rd(B, d);
    check("clr_status", 256'(d), 256'h0000);
    load(16, 16'h0040, 16'h0060);
    check("clr_frame_valid", 256'(bus_if.out_valid), 256'd1);
    check("clr_xr_slice0", 256'(bus_if.xr_flat[0 +: 16]), 256'h0040);
    check("clr_xr_slice1", 256'(bus_if.xr_flat[16 +: 16]), 256'h0044);
    idle(1'b1);
    idle(1'b0);

    // Bus corner cases.
    wr(B + 14'd1, 16'hBEEF);
    bus_cycle(1'b1, 2'b01, B + 14'd2, 16'h1234, 1'b0);
    bus_cycle(1'b1, 2'b10, B + 14'd1, 16'h5678, 1'b0);
    wr(B + 14'd5, 16'hFFFF);
    rd(B, d);
    check("byte_wr_count", 256'(d), 256'h0000);
    rd(B + 14'd1, d);
    check("datar_read", 256'(d), 256'hBEEF);
    rd(B + 14'd2, d);
    check("datai_read", 256'(d), 256'h0000);
    rd(B + 14'd5, d);
    check("unmapped_read", 256'(d), 256'h0000);

    // CLR coincident with handshake, ovf set beforehand.
    load(16, 16'h0050, 16'h0000);
    wr(B + 14'd1, 16'h1111);
    bus_cycle(1'b1, 2'b11, B, 16'h0002, 1'b1);
    idle(1'b0);
    check("clr_hs_valid", 256'(bus_if.out_valid), 256'd0);
    rd(B, d);
    check("clr_hs_status", 256'(d), 256'h0000);

    // Asynchronous reset in the middle of a partial frame.
    load(5, 16'h0A00, 16'h0B00);
    @(negedge mclk);
    #3 puc_rst = 1'b1;
    #1;
    check("rst_valid", 256'(bus_if.out_valid), 256'd0);
    check("rst_xr", bus_if.xr_flat, 256'd0);
    check("rst_xi", bus_if.xi_flat, 256'd0);
    idle(1'b0);
    @(negedge mclk);
    #1 puc_rst = 1'b0;
    rd(B, d);
    check("rst_status", 256'(d), 256'h0000);
    rd(B + 14'd1, d);
    check("rst_restage", 256'(d), 256'h0000);

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      logic rdy;
      logic [15:0] rv;
      rdy = ($urandom_range(0, 3) == 0);
      rv  = 16'($urandom);
      r   = int'($urandom_range(0, 15));
      if (r < 5)       bus_cycle(1'b1, 2'b11, B + 14'd1, rv, rdy);
      else if (r < 10) bus_cycle(1'b1, 2'b11, B + 14'd2, rv, rdy);
      else if (r == 10)
        bus_cycle(1'b1, 2'b11, B, (rv & 16'hFFFD) | (($urandom_range(0, 7) == 0) ? 16'h0002 : 16'h0000), rdy);
      else if (r == 11)
        bus_cycle(1'b1, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10,
                  B + 14'($urandom_range(0, 2)), rv, rdy);
      else if (r == 12) bus_cycle(1'b1, 2'b00, B + 14'($urandom_range(0, 5)), 16'd0, rdy);
      else if (r == 13) bus_cycle(1'b1, 2'b11, B + 14'($urandom_range(3, 9)), rv, rdy);
      else              bus_cycle(1'b0, 2'b00, 14'($urandom), rv, rdy);
    end
    idle(1'b0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
